// File: rtl/gray_alu_pkg.sv
// Shared constants and types for the grayscale ALU pipeline.
package gray_alu_pkg;

    // Default channel and coefficient widths.
    localparam int DATA_W_DEF = 4;
    localparam int FRAC_W_DEF = 6;

    // Default luminance weights (value / 2^FRAC_W).
    localparam int WR_DEF = 14;
    localparam int WG_DEF = 46;
    localparam int WB_DEF = 5;

    // Product and sum widths for the default configuration.
    localparam int PROD_W = DATA_W_DEF + FRAC_W_DEF;
    localparam int SUM_W  = PROD_W + 2;

    // Coefficient register select.
    typedef enum logic [1:0] {
        CFG_SEL_R    = 2'd0,
        CFG_SEL_G    = 2'd1,
        CFG_SEL_B    = 2'd2,
        CFG_SEL_NONE = 2'd3
    } cfgSel_e;

    // Product width for an arbitrary channel/coefficient width pair.
    function automatic int prodWidth(input int dataW, input int fracW);
        return dataW + fracW;
    endfunction

endpackage

// File: rtl/gray_alu_stage2.sv
// Combinational add + round + clamp: three weighted products in, Y and saturation flag out.
module gray_alu_stage2
    import gray_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    localparam int PW    = prodWidth(DATA_W, FRAC_W)
) (
    input  logic [PW-1:0]     prodR,
    input  logic [PW-1:0]     prodG,
    input  logic [PW-1:0]     prodB,
    output logic [DATA_W-1:0] y,
    output logic              sat
);

    localparam int SW = PW + 2;
    localparam int YW = SW - FRAC_W;
    localparam logic [SW-1:0] ROUND = SW'(2 ** (FRAC_W - 1));
    localparam logic [YW-1:0] Y_MAX = YW'((2 ** DATA_W) - 1);

    logic [SW-1:0] sum;
    logic [YW-1:0] yRaw;

    // Sum with half-LSB rounding, scale down, clamp to the channel range.
    always_comb begin
        sum  = SW'(prodR) + SW'(prodG) + SW'(prodB) + ROUND;
        yRaw = sum[SW-1:FRAC_W];
        if (yRaw > Y_MAX) begin
            y   = '1;
            sat = 1'b1;
        end else begin
            y   = yRaw[DATA_W-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/gray_alu_pipe.sv
// Two-stage RGB-to-luminance pipeline with programmable weights, per-beat bypass
// and valid/ready handshake on both sides.
module gray_alu_pipe
    import gray_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int WR_RST = WR_DEF,
    parameter int WG_RST = WG_DEF,
    parameter int WB_RST = WB_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_alu_en,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [FRAC_W-1:0] cfg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_g,
    output logic [DATA_W-1:0] out_b,
    output logic              out_sat
);

    localparam int PW = prodWidth(DATA_W, FRAC_W);

    // Coefficient registers.
    logic [FRAC_W-1:0] wR, wG, wB;

    // Stage 1 state.
    logic              s1Valid;
    logic              s1AluEn;
    logic [DATA_W-1:0] s1R, s1G, s1B;
    logic [PW-1:0]     s1ProdR, s1ProdG, s1ProdB;

    // Stage 2 state (drives the outputs directly).
    logic              s2Valid;

    // Handshake and combinational stage-2 result.
    logic              s2Advance;
    logic              accept;
    logic [DATA_W-1:0] yComb;
    logic              satComb;

    // Each stage may load when its successor is empty or draining this cycle.
    always_comb begin
        s2Advance = ~s2Valid | out_ready;
        in_ready  = ~s1Valid | s2Advance;
        accept    = in_valid & in_ready;
    end

    assign out_valid = s2Valid;

    gray_alu_stage2 #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) uStage2 (
        .prodR (s1ProdR),
        .prodG (s1ProdG),
        .prodB (s1ProdB),
        .y     (yComb),
        .sat   (satComb)
    );

    // Coefficient writes; a beat accepted on the same edge still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wR <= FRAC_W'(WR_RST);
            wG <= FRAC_W'(WG_RST);
            wB <= FRAC_W'(WB_RST);
        end else if (cfg_we) begin
            case (cfgSel_e'(cfg_sel))
                CFG_SEL_R:    wR <= cfg_data;
                CFG_SEL_G:    wG <= cfg_data;
                CFG_SEL_B:    wB <= cfg_data;
                CFG_SEL_NONE: ;
            endcase
        end
    end

    // Stage 1: capture the beat and its three weighted products on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1AluEn <= 1'b0;
            s1R     <= '0;
            s1G     <= '0;
            s1B     <= '0;
            s1ProdR <= '0;
            s1ProdG <= '0;
            s1ProdB <= '0;
        end else if (in_ready) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1AluEn <= in_alu_en;
                s1R     <= in_r;
                s1G     <= in_g;
                s1B     <= in_b;
                s1ProdR <= PW'(in_r) * PW'(wR);
                s1ProdG <= PW'(in_g) * PW'(wG);
                s1ProdB <= PW'(in_b) * PW'(wB);
            end
        end
    end

    // Stage 2: register either the clamped luminance or the raw bypass pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid <= 1'b0;
            out_r   <= '0;
            out_g   <= '0;
            out_b   <= '0;
            out_sat <= 1'b0;
        end else if (s2Advance) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                if (s1AluEn) begin
                    out_r   <= yComb;
                    out_g   <= yComb;
                    out_b   <= yComb;
                    out_sat <= satComb;
                end else begin
                    out_r   <= s1R;
                    out_g   <= s1G;
                    out_b   <= s1B;
                    out_sat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/gray_alu_pipe.md
Name: gray_alu_pipe

Overview:
- Parametrised, pipelined successor to the combinational multiplier/adder pair.
- Converts one RGB pixel per beat to luminance: Y = round(Wr*R + Wg*G + Wb*B) in fixed point, with saturation.
- Coefficients are programmable at run time. Per-beat bypass mode passes RGB through unchanged.
- Sits between the pixel source and the display/frame writer; valid/ready handshake on both sides with full backpressure.

Parameters:
- DATA_W, 4, bits per colour channel.
- FRAC_W, 6, fractional bits of each coefficient (coefficient width = FRAC_W).
- WR_RST, 14, reset value of red weight (0.21875).
- WG_RST, 46, reset value of green weight (0.71875).
- WB_RST, 5, reset value of blue weight (0.078125).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_r / in_g / in_b  in  DATA_W each  input channels.
- in_alu_en  in  1  1 = grayscale, 0 = bypass; travels with the beat.
- cfg_we  in  1  coefficient write strobe.
- cfg_sel  in  2  0 = Wr, 1 = Wg, 2 = Wb, 3 = ignored.
- cfg_data  in  FRAC_W  coefficient value (unsigned, value/2^FRAC_W).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_r / out_g / out_b  out  DATA_W each  result; all three equal Y in gray mode.
- out_sat  out  1  result was clamped (gray mode only).

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - both stage valids = 0, out_valid = 0;
  - out_r/g/b = 0, out_sat = 0;
  - coefficient registers = WR_RST/WG_RST/WB_RST.
- Pipeline: two registered stages. Latency is 2 cycles from input acceptance to out_valid when unstalled. Throughput is 1 beat/cycle.
  - S1 (multiply): registers pR = R*Wr, pG = G*Wg, pB = B*Wb, each DATA_W+FRAC_W bits. It also registers the raw RGB and alu_en.
  - S2 (add/round/clamp): sum = pR+pG+pB + 2^(FRAC_W-1), width DATA_W+FRAC_W+2.
    - Y = sum >> FRAC_W.
    - If Y > 2^DATA_W-1: Y = 2^DATA_W-1 and out_sat = 1; else out_sat = 0.
- Bypass (alu_en = 0 on a beat):
  - out_r/g/b = that beat's in_r/g/b, out_sat = 0.
  - Same latency as gray mode; beats never reorder across mode changes.
- Handshake:
  - An input is accepted when in_valid & in_ready. An output is consumed when out_valid & out_ready.
  - Each stage advances when its successor is empty or being drained in the same cycle.
  - in_ready = ~s1_valid | s2_advance. It is combinational from out_ready; there is no path from in_valid.
  - While out_valid = 1 and out_ready = 0, out_* and out_sat hold stable.
  - Stall capacity is 2 beats: with out_ready low, in_ready falls after two accepted beats.
  - Simultaneous accept and drain while full is allowed and loses nothing.
- Coefficient write:
  - cfg_we with cfg_sel 0..2 updates the selected register at the clock edge. cfg_sel = 3 is a no-op.
  - A beat accepted in the same cycle as a write uses the old value. Beats accepted afterwards use the new value.
  - Beats already in S1/S2 are unaffected.
- Reset mid-stream: all in-flight beats are discarded, out_valid drops immediately (async), and coefficients return to reset values.
- No X propagation: data registers load only on stage advance. Invalid stages hold their old data but out_valid = 0.

Decomposition:
- Shared package gray_alu_pkg holds:
  - CFG_SEL_R/G/B/NONE constants;
  - default weight constants;
  - helper width constants PROD_W = DATA_W+FRAC_W and SUM_W = PROD_W+2.
- One natural sub-module: gray_alu_stage2, the combinational add + round + clamp taking three products and producing Y and sat. It is reusable by the verification reference model.

Test Plan:
- Defaults, gray, R=8 G=4 B=2 -> 112+184+10+32 = 338 -> Y=5 on all outputs, out_sat=0, out_valid exactly 2 cycles after accept.
- Defaults, R=G=B=15 -> sum 1007 -> Y=15, out_sat=0; R=G=B=0 -> Y=0.
- Write Wr=Wg=Wb=63, then R=G=B=15 -> sum 2867 -> raw 44 clamped -> Y=15, out_sat=1. A beat accepted in the write cycle still uses defaults.
- Bypass: alu_en=0, R=3 G=9 B=12 -> out 3/9/12, out_sat=0. Alternate gray/bypass on back-to-back beats -> order and values preserved.
- Backpressure: stream 5 beats with out_ready low for 4 cycles -> in_ready drops after beat 2, outputs held stable, all 5 beats emerge in order with no duplication.
- Assert rst_n low with 2 beats in flight -> out_valid=0 immediately, coefficients back to 14/46/5, the next beat after release computes with defaults.
